vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Raster timing generator for the 1280x1024@60 Hz VGA output path. It sits directly upstream of the pixel generator.
- Supplies the undelayed pixel/line counters that pixel generator uses to address its image ROM.
- Supplies visible_region and the HS/VS/BLANK outputs, delayed to match that ROM read latency so colour and sync reach the DAC aligned.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FRONT, 48, horizontal front porch (pixels)
H_SYNC, 112, horizontal sync width (pixels)
H_BACK, 248, horizontal back porch (pixels); H_TOTAL = 1688
V_ACTIVE, 1024, active lines per frame
V_FRONT, 1, vertical front porch (lines)
V_SYNC, 3, vertical sync width (lines)
V_BACK, 38, vertical back porch (lines); V_TOTAL = 1066
HS_POL, 1'b1, asserted level of VGA_HS
VS_POL, 1'b1, asserted level of VGA_VS
PIPE_DELAY, 2, cycles of delay on visible_region/HS/VS/BLANK_N; legal range 0..4

Ports:
VGA_CLK  in  1  pixel clock, 108 MHz
reset_n  in  1  asynchronous, active-low reset
pixel_location  out  16  horizontal count 0..H_TOTAL-1, undelayed
line_value  out  16  vertical count 0..V_TOTAL-1, undelayed
visible_region  out  1  active-area flag, delayed PIPE_DELAY cycles
VGA_HS  out  1  horizontal sync, delayed PIPE_DELAY cycles
VGA_VS  out  1  vertical sync, delayed PIPE_DELAY cycles
VGA_BLANK_N  out  1  equals visible_region
VGA_SYNC_N  out  1  constant 0 (no sync-on-green)
line_start  out  1  1-cycle pulse while pixel_location==0, undelayed
frame_start  out  1  1-cycle pulse while pixel_location==0 and line_value==0, undelayed

Behaviour:
- Phase order on each axis: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Both counts start at 0 in ACTIVE.
- Horizontal counter:
  - Increments every VGA_CLK.
  - At H_TOTAL-1 it wraps to 0 and issues a one-cycle line-advance enable.
- Vertical counter:
  - Increments only on line-advance.
  - At V_TOTAL-1 with line-advance it wraps to 0.
- Horizontal phase decode:
  - ACTIVE: 0..H_ACTIVE-1
  - SYNC: H_ACTIVE+H_FRONT .. H_ACTIVE+H_FRONT+H_SYNC-1, i.e. 1328..1439
- Vertical phase decode:
  - ACTIVE: 0..V_ACTIVE-1
  - SYNC: V_ACTIVE+V_FRONT .. +V_SYNC-1, i.e. lines 1025..1027
- Phase is held as a registered state per axis and updated on counter boundary compares. Raw flags:
  - raw_vis = H ACTIVE and V ACTIVE
  - raw_hs = H SYNC
  - raw_vs = V SYNC
- VGA_VS switches at the start of a line (pixel_location==0), not mid-line.
- Delay line: raw_vis, raw_hs and raw_vs each pass through a PIPE_DELAY-deep register chain.
  - PIPE_DELAY=0 gives registered-decode outputs with zero extra latency.
  - Counters are never delayed.
- Sync level at outputs: VGA_HS = HS_POL when delayed hs is asserted, else ~HS_POL. VGA_VS is the same using VS_POL.
- Counter outputs are zero-extended to 16 bits.
- Pulse outputs: line_start and frame_start are registered next-state decodes, so each is high exactly in the cycle its counters hold the qualifying value.
- Reset (async, while reset_n=0), regardless of clock:
  - Counters 0; both phase states ACTIVE.
  - All delay stages cleared: visible_region=0, VGA_BLANK_N=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL.
  - line_start=1 and frame_start=1, consistent with counters at (0,0).
- After reset release:
  - The first rising edge advances pixel_location to 1 and drops both pulses.
  - Delayed flags become valid after PIPE_DELAY edges.
- Reset mid-frame: immediate return to reset values; the next frame starts cleanly at (0,0). No partial-line recovery.
- Elaboration-time checks (assertion or generate error):
  - H_TOTAL and V_TOTAL ≤ 65535
  - every phase width ≥ 1
  - PIPE_DELAY within 0..4

Decomposition:
- Package vga_timing_pkg holds:
  - the 1280x1024 timing constants and derived H_TOTAL/V_TOTAL
  - typedef enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t
  - the PIPE_DELAY default of 2, matching the pixel generator's ROM latency
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical). Its interface:
  - parameters for the four phase widths
  - inputs: clock, async reset, advance enable
  - outputs: count, phase_t phase, wrap pulse
- The top level holds the delay lines, polarity mapping and start pulses.

Test Plan:
1. Release reset, run 1688 cycles -> pixel_location wraps 1687->0, line_value=1, line_start high one cycle, frame_start stays 0.
2. PIPE_DELAY=2, observe line 0 -> VGA_HS goes high 2 cycles after pixel_location==1328, stays high exactly 112 cycles, low otherwise.
3. Run a full frame -> VGA_VS high for exactly 3×1688 cycles, first rising 2 cycles after (line 1025, pixel 0). visible_region high for exactly 1,310,720 cycles, 1280 per line for lines 0..1023.
4. Run 1688×1066 = 1,799,408 cycles after release -> counters return to (0,0) with frame_start pulse; two consecutive frame_start pulses are exactly 1,799,408 cycles apart.
5. Assert reset_n=0 at line 500, pixel 700 with clock stopped -> all outputs take reset values without a clock edge. After release, the counts restart 1, 2, 3… on line 0.
6. Rebuild with PIPE_DELAY=0 and HS_POL=0 -> VGA_HS low during pixel counts 1328..1439 with no delay versus the counter, high elsewhere.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the 1280x1024@60 Hz raster generator.
package vga_timing_pkg;

  // Counter outputs are 16 bits wide, so each axis total must fit in 16 bits.
  localparam int CNT_W = 16;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FRONT  = 48;
  localparam int DEF_H_SYNC   = 112;
  localparam int DEF_H_BACK   = 248;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int DEF_V_ACTIVE = 1024;
  localparam int DEF_V_FRONT  = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BACK   = 38;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Matches the read latency of the pixel generator's image ROM.
  localparam int DEF_PIPE_DELAY = 2;
  localparam int MAX_PIPE_DELAY = 4;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  // The three raster flags that travel together through the delay line.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } sync_flags_t;

  // Truncates an elaboration-time integer to counter width.
  function automatic logic [CNT_W-1:0] to_cnt(input int value);
    return value[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter plus a registered phase state that
// always describes the current count value.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output phase_t           phase,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  localparam logic [CNT_W-1:0] ACTIVE_END = to_cnt(ACTIVE - 1);
  localparam logic [CNT_W-1:0] FRONT_END  = to_cnt(ACTIVE + FRONT - 1);
  localparam logic [CNT_W-1:0] SYNC_END   = to_cnt(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST       = to_cnt(TOTAL - 1);

  generate
    if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_width
      $error("vga_axis_counter: every phase width must be at least 1");
    end
    if (TOTAL > 65535) begin : g_bad_total
      $error("vga_axis_counter: axis total must not exceed 65535");
    end
  endgenerate

  // Count and phase advance together; the phase moves on when the count
  // leaves the last value of the current phase.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= PH_ACTIVE;
    end else if (advance) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
      case (phase)
        PH_ACTIVE: if (count == ACTIVE_END) phase <= PH_FRONT;
        PH_FRONT:  if (count == FRONT_END)  phase <= PH_SYNC;
        PH_SYNC:   if (count == SYNC_END)   phase <= PH_BACK;
        PH_BACK:   if (count == LAST)       phase <= PH_ACTIVE;
        default:                            phase <= PH_ACTIVE;
      endcase
    end
  end

  // Single-cycle pulse on the advance that takes the count back to zero.
  assign wrap = advance && (count == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: undelayed counters for ROM addressing, and sync /
// blank flags delayed to line up with the ROM read data at the DAC.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic        VGA_CLK,
  input  logic        reset_n,
  output logic [15:0] pixel_location,
  output logic [15:0] line_value,
  output logic        visible_region,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        line_start,
  output logic        frame_start
);

  generate
    if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY must be within 0..4");
    end
  endgenerate

  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  phase_t           h_phase;
  phase_t           v_phase;
  logic             h_wrap;
  logic             v_wrap;
  sync_flags_t      raw;
  sync_flags_t      dly;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk     (VGA_CLK),
    .rst_n   (reset_n),
    .advance (1'b1),
    .count   (h_count),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  // The vertical axis only steps when a line ends, so VS changes at pixel 0.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk     (VGA_CLK),
    .rst_n   (reset_n),
    .advance (h_wrap),
    .count   (v_count),
    .phase   (v_phase),
    .wrap    (v_wrap)
  );

  assign pixel_location = h_count;
  assign line_value     = v_count;

  // Flags decoded from the registered phases, aligned with the current counts.
  assign raw.vis = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign raw.hs  = (h_phase == PH_SYNC);
  assign raw.vs  = (v_phase == PH_SYNC);

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign dly = raw;
    end else begin : g_delay
      sync_flags_t stage [PIPE_DELAY];

      // Shift the raster flags down a PIPE_DELAY-deep chain.
      // NOTE: this small array is cleared on reset on purpose, so the sync
      // outputs are deasserted and blank is active from the moment reset hits.
      always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_DELAY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= raw;
          for (int i = 1; i < PIPE_DELAY; i++) stage[i] <= stage[i-1];
        end
      end

      assign dly = stage[PIPE_DELAY-1];
    end
  endgenerate

  assign visible_region = dly.vis;
  assign VGA_BLANK_N    = dly.vis;
  assign VGA_HS         = dly.hs ? HS_POL : ~HS_POL;
  assign VGA_VS         = dly.vs ? VS_POL : ~VS_POL;
  assign VGA_SYNC_N     = 1'b0;

  // Start pulses are next-state decodes: high while the counters sit at 0.
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (full timing PIPE_DELAY=2, a tiny
// raster PIPE_DELAY=2, full timing PIPE_DELAY=0 with inverted sync polarity)
// compared each cycle against a cycle-index raster model.
module tb_vga_timing_gen;

  typedef struct {
    int   ha, hf, hs, hb;
    int   va, vf, vs, vb;
    int   pd;
    logic hpol, vpol;
  } timing_t;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        vis;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        sync_n;
    logic        ls;
    logic        fs;
  } obs_t;

  logic  clk     = 1'b0;
  bit    clk_run = 1'b1;
  logic  reset_n = 1'b0;
  int    k       = 0;
  int    total   = 0;
  int    bad     = 0;

  timing_t tim  [3];
  string   name [3] = '{"def", "sml", "pd0"};

  logic [15:0] px [3];
  logic [15:0] ln [3];
  logic        vis[3];
  logic        hs [3];
  logic        vs [3];
  logic        bn [3];
  logic        sn [3];
  logic        ls [3];
  logic        fs [3];

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vga_timing_gen u_def (
    .VGA_CLK(clk), .reset_n(reset_n),
    .pixel_location(px[0]), .line_value(ln[0]), .visible_region(vis[0]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bn[0]), .VGA_SYNC_N(sn[0]),
    .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(2)
  ) u_sml (
    .VGA_CLK(clk), .reset_n(reset_n),
    .pixel_location(px[1]), .line_value(ln[1]), .visible_region(vis[1]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bn[1]), .VGA_SYNC_N(sn[1]),
    .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(0)
  ) u_pd0 (
    .VGA_CLK(clk), .reset_n(reset_n),
    .pixel_location(px[2]), .line_value(ln[2]), .visible_region(vis[2]),
    .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_BLANK_N(bn[2]), .VGA_SYNC_N(sn[2]),
    .line_start(ls[2]), .frame_start(fs[2])
  );

  function automatic obs_t get_obs(input int d);
    obs_t o;
    o = {px[d], ln[d], vis[d], bn[d], hs[d], vs[d], sn[d], ls[d], fs[d]};
    return o;
  endfunction

  // Expected outputs kk rising edges after reset release. Counters follow
  // kk directly; delayed flags describe raster position kk - pd.
  function automatic obs_t model(input int d, input int kk);
    timing_t t;
    obs_t    e;
    int      htot, vtot, idx, hh, vv;
    t    = tim[d];
    htot = t.ha + t.hf + t.hs + t.hb;
    vtot = t.va + t.vf + t.vs + t.vb;
    e.h      = 16'(kk % htot);
    e.v      = 16'((kk / htot) % vtot);
    e.ls     = ((kk % htot) == 0);
    e.fs     = e.ls && (((kk / htot) % vtot) == 0);
    e.sync_n = 1'b0;
    if (kk < t.pd) begin
      e.vis = 1'b0;
      e.hs  = ~t.hpol;
      e.vs  = ~t.vpol;
    end else begin
      idx   = kk - t.pd;
      hh    = idx % htot;
      vv    = (idx / htot) % vtot;
      e.vis = (hh < t.ha) && (vv < t.va);
      e.hs  = (hh >= t.ha + t.hf && hh < t.ha + t.hf + t.hs) ? t.hpol : ~t.hpol;
      e.vs  = (vv >= t.va + t.vf && vv < t.va + t.vf + t.vs) ? t.vpol : ~t.vpol;
    end
    e.blank = e.vis;
    return e;
  endfunction

  task automatic tick();
    clk_run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    k = 0;
  endtask

  task automatic hold_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) tick();
  endtask

  // Reset held with the clock running: every build shows its (0,0) state.
  task automatic test_reset();
    obs_t o, e;
    hold_reset(3);
    for (int d = 0; d < 3; d++) begin
      o = get_obs(d);
      e = model(d, 0);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_%s got=%h exp=%h", name[d], o, e);
      end
    end
  endtask

  // First line after release: per-cycle model check, one line_start pulse
  // at the 1687->0 wrap, no frame_start.
  task automatic test_line_wrap();
    obs_t o, e;
    int   ls_cnt, fs_cnt;
    ls_cnt = 0;
    fs_cnt = 0;
    release_reset();
    repeat (1700) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        o = get_obs(d);
        e = model(d, k);
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL line_wrap_%s k=%0d got=%h exp=%h", name[d], k, o, e);
        end
      end
      if (ls[0] === 1'b1) ls_cnt++;
      if (fs[0] === 1'b1) fs_cnt++;
    end
    total++;
    if (ls_cnt !== 1) begin
      bad++;
      $display("FAIL line_start_count got=%0d exp=1", ls_cnt);
    end
    total++;
    if (fs_cnt !== 0) begin
      bad++;
      $display("FAIL frame_start_line0 got=%0d exp=0", fs_cnt);
    end
  endtask

  // Line 0 horizontal sync: delayed build asserts HS from edge 1330 for 112
  // cycles; the undelayed, active-low build asserts from edge 1328.
  task automatic test_hsync();
    int hi_cnt, hi_first, lo_cnt, lo_first;
    hi_cnt = 0; hi_first = -1; lo_cnt = 0; lo_first = -1;
    hold_reset(2);
    release_reset();
    repeat (1700) begin
      tick();
      if (hs[0] === 1'b1) begin
        hi_cnt++;
        if (hi_first < 0) hi_first = k;
      end
      if (hs[2] === 1'b0) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = k;
      end
    end
    total++;
    if (hi_first !== 1330) begin bad++; $display("FAIL hs_rise_def got=%0d exp=1330", hi_first); end
    total++;
    if (hi_cnt !== 112) begin bad++; $display("FAIL hs_width_def got=%0d exp=112", hi_cnt); end
    total++;
    if (lo_first !== 1328) begin bad++; $display("FAIL hs_fall_pd0 got=%0d exp=1328", lo_first); end
    total++;
    if (lo_cnt !== 112) begin bad++; $display("FAIL hs_width_pd0 got=%0d exp=112", lo_cnt); end
  endtask

  // Two full frames of the tiny raster (19 x 11 = 209 cycles per frame).
  task automatic test_frame();
    obs_t o, e;
    int   vs_cnt, vs_first, vis_cnt, fs_first, fs_gap, fs_last;
    vs_cnt = 0; vs_first = -1; vis_cnt = 0; fs_first = -1; fs_gap = -1; fs_last = -1;
    hold_reset(2);
    release_reset();
    repeat (2 * 209 + 4) begin
      tick();
      o = get_obs(1);
      e = model(1, k);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL frame_sml k=%0d got=%h exp=%h", k, o, e);
      end
      if (k >= 2 && k < 2 + 209) begin
        if (vs[1] === 1'b1) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = k;
        end
        if (vis[1] === 1'b1) vis_cnt++;
      end
      if (fs[1] === 1'b1) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_gap < 0) fs_gap = k - fs_last;
        fs_last = k;
      end
    end
    total++;
    if (vs_cnt !== 2 * 19) begin bad++; $display("FAIL vs_width got=%0d exp=38", vs_cnt); end
    total++;
    if (vs_first !== 6 * 19 + 2) begin bad++; $display("FAIL vs_rise got=%0d exp=116", vs_first); end
    total++;
    if (vis_cnt !== 50) begin bad++; $display("FAIL visible_count got=%0d exp=50", vis_cnt); end
    total++;
    if (fs_first !== 209) begin bad++; $display("FAIL frame_start_first got=%0d exp=209", fs_first); end
    total++;
    if (fs_gap !== 209) begin bad++; $display("FAIL frame_start_gap got=%0d exp=209", fs_gap); end
  endtask

  // Reset asserted mid-raster with the clock stopped, then restart at (0,0).
  task automatic test_mid_reset();
    obs_t o, e;
    repeat (4) begin
      hold_reset(2);
      release_reset();
      repeat ($urandom_range(600, 30)) tick();
      clk_run = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
        o = get_obs(d);
        e = model(d, 0);
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL async_reset_%s got=%h exp=%h", name[d], o, e);
        end
      end
      #2;
      release_reset();
      #2;
      repeat (3) begin
        tick();
        for (int d = 0; d < 3; d++) begin
          o = get_obs(d);
          e = model(d, k);
          total++;
          if (o !== e) begin
            bad++;
            $display("FAIL restart_%s k=%0d got=%h exp=%h", name[d], k, o, e);
          end
        end
      end
    end
  endtask

  // Random reset pulse lengths and random run lengths, full per-cycle check.
  task automatic test_random();
    obs_t o, e;
    repeat (6) begin
      hold_reset($urandom_range(5, 1));
      release_reset();
      repeat ($urandom_range(500, 20)) begin
        tick();
        for (int d = 0; d < 3; d++) begin
          o = get_obs(d);
          e = model(d, k);
          total++;
          if (o !== e) begin
            bad++;
            $display("FAIL random_%s k=%0d got=%h exp=%h", name[d], k, o, e);
          end
        end
      end
    end
  endtask

  initial begin
    tim[0] = '{1280, 48, 112, 248, 1024, 1, 3, 38, 2, 1'b1, 1'b1};
    tim[1] = '{10, 2, 3, 4, 5, 1, 2, 3, 2, 1'b1, 1'b1};
    tim[2] = '{1280, 48, 112, 248, 1024, 1, 3, 38, 0, 1'b0, 1'b0};
    @(negedge clk);
    test_reset();
    test_line_wrap();
    test_hsync();
    test_frame();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
